// File: rtl/noc_vec_pkg.sv
// Shared op/source encodings, FSM states and config legality for noc_vec_stream.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package noc_vec_pkg;

  localparam logic [1:0] OP_PASS    = 2'd0;
  localparam logic [1:0] OP_ADD     = 2'd1;
  localparam logic [1:0] OP_RELU    = 2'd2;
  localparam logic [1:0] OP_ADDRELU = 2'd3;

  localparam logic [1:0] FROM_NONE = 2'd0;
  localparam logic [1:0] FROM_SELF = 2'd1;
  localparam logic [1:0] FROM_PREV = 2'd2;
  localparam logic [1:0] FROM_BOTH = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Operating mode; shifts live beside it because their width is a module parameter.
  typedef struct packed {
    logic [1:0] op;
    logic [1:0] from;
  } mode_t;

  function automatic logic op_adds(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_ADDRELU);
  endfunction

  function automatic logic op_relu(input logic [1:0] op);
    return (op == OP_RELU) || (op == OP_ADDRELU);
  endfunction

  // Adding ops need both sources; single-source ops need exactly one; no source means idle.
  function automatic logic cfg_legal(input logic [1:0] op, input logic [1:0] from);
    logic ok;
    if (from == FROM_NONE)
      ok = 1'b1;
    else if (op_adds(op))
      ok = (from == FROM_BOTH);
    else
      ok = (from == FROM_SELF) || (from == FROM_PREV);
    return ok;
  endfunction

endpackage

// File: rtl/noc_vec_lane.sv
// One lane: shifted prev + self with saturation (or source select), plus ReLU on the staged value.
// Latency: purely combinational.
// Backpressure: none; the caller decides when results are captured.
module noc_vec_lane
  import noc_vec_pkg::*;
#(
  parameter int DW  = 8,
  parameter int SHW = 3
) (
  input  logic [1:0]     op,
  input  logic [1:0]     from,
  input  logic [SHW-1:0] shift_l,
  input  logic [SHW-1:0] shift_r,
  input  logic [DW-1:0]  self_lane,
  input  logic [DW-1:0]  prev_lane,
  input  logic           relu_en,
  input  logic [DW-1:0]  s1_lane,
  output logic [DW-1:0]  res_lane,
  output logic           sat,
  output logic [DW-1:0]  out_lane
);

  // Wide enough that neither the left shift nor the add can wrap before clamping.
  localparam int WW = DW + (1 << SHW) + 1;
  localparam logic signed [WW-1:0] MAXV = {{(WW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = {{(WW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [WW-1:0] self_ext;
  logic signed [WW-1:0] prev_ext;
  logic signed [WW-1:0] prev_term;
  logic signed [WW-1:0] sum_w;

  assign self_ext  = {{(WW-DW){self_lane[DW-1]}}, self_lane};
  assign prev_ext  = {{(WW-DW){prev_lane[DW-1]}}, prev_lane};
  assign prev_term = (prev_ext <<< shift_l) >>> shift_r;
  assign sum_w     = self_ext + prev_term;

  // Adding ops clamp to the signed lane range; single-source ops pass the raw source.
  always_comb begin
    sat      = 1'b0;
    res_lane = self_lane;
    if (op_adds(op)) begin
      if (sum_w > MAXV) begin
        res_lane = {1'b0, {(DW-1){1'b1}}};
        sat      = 1'b1;
      end else if (sum_w < MINV) begin
        res_lane = {1'b1, {(DW-1){1'b0}}};
        sat      = 1'b1;
      end else begin
        res_lane = sum_w[DW-1:0];
      end
    end else if (from == FROM_PREV) begin
      res_lane = prev_lane;
    end
  end

  assign out_lane = (relu_en && s1_lane[DW-1]) ? '0 : s1_lane;

endmodule

// File: rtl/noc_vec_stream.sv
// Streams per-lane self+prev (shift/saturate/ReLU) with run-time reconfiguration that drains first.
// Latency: 2 cycles from input handshake to out_valid; 1 beat/cycle with out_ready high.
// Backpressure: out_ready low stalls stage 2 then stage 1, then drops self/prev ready; drain blocks inputs.
module noc_vec_stream
  import noc_vec_pkg::*;
#(
  parameter int LANES = 256,
  parameter int DW    = 8,
  parameter int SHW   = 3,
  parameter int CNTW  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_valid,
  input  logic [1:0]          cfg_op,
  input  logic [1:0]          cfg_from,
  input  logic [SHW-1:0]      cfg_shift_l,
  input  logic [SHW-1:0]      cfg_shift_r,
  output logic                cfg_busy,
  output logic                cfg_err,
  input  logic                self_valid,
  output logic                self_ready,
  input  logic [LANES*DW-1:0] self_data,
  input  logic                prev_valid,
  output logic                prev_ready,
  input  logic [LANES*DW-1:0] prev_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_data,
  output logic [CNTW-1:0]     sat_cnt
);

  localparam int VW = LANES * DW;

  state_t         state_q, state_d;
  mode_t          act_mode, pend_mode, cfg_mode, cand_mode;
  logic [SHW-1:0] act_shl, act_shr, pend_shl, pend_shr, cand_shl, cand_shr;
  logic           resolve, apply, err_set, pend_load;
  logic           s1_v, s1_sat, s1_relu, s1_ready, s2_adv, fire, pipe_empty;
  logic [VW-1:0]  s1_dat, sum_bus, relu_bus;
  logic [LANES-1:0] sat_bus;

  assign cfg_mode.op   = cfg_op;
  assign cfg_mode.from = cfg_from;
  assign cfg_busy      = (state_q == DRAIN);
  assign pipe_empty    = !s1_v && !out_valid;
  assign s2_adv        = s1_v && (!out_valid || out_ready);
  assign s1_ready      = !s1_v || s2_adv;

  // Last config wins: a strobe in the resolving cycle overrides the stored pending one.
  assign cand_mode = cfg_valid ? cfg_mode    : pend_mode;
  assign cand_shl  = cfg_valid ? cfg_shift_l : pend_shl;
  assign cand_shr  = cfg_valid ? cfg_shift_r : pend_shr;
  assign resolve   = ((state_q == IDLE) && cfg_valid) || ((state_q == DRAIN) && pipe_empty);

  // Next state: IDLE resolves a strobe at once, RUN parks it as pending, DRAIN resolves once empty.
  always_comb begin
    state_d   = state_q;
    apply     = 1'b0;
    err_set   = 1'b0;
    pend_load = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_valid) begin
          pend_load = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: pend_load = cfg_valid;
      default: ;
    endcase
    if (resolve) begin
      if (cfg_legal(cand_mode.op, cand_mode.from)) begin
        apply   = 1'b1;
        state_d = (cand_mode.from == FROM_NONE) ? IDLE : RUN;
      end else begin
        err_set = 1'b1;
        state_d = (act_mode.from == FROM_NONE) ? IDLE : RUN;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Active/pending config and the sticky rejection flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      act_mode  <= '0;
      act_shl   <= '0;
      act_shr   <= '0;
      pend_mode <= '0;
      pend_shl  <= '0;
      pend_shr  <= '0;
      cfg_err   <= 1'b0;
    end else begin
      if (apply) begin
        act_mode <= cand_mode;
        act_shl  <= cand_shl;
        act_shr  <= cand_shr;
      end
      if (pend_load) begin
        pend_mode <= cfg_mode;
        pend_shl  <= cfg_shift_l;
        pend_shr  <= cfg_shift_r;
      end
      if (err_set) cfg_err <= 1'b1;
    end
  end

  // Input join: readies never look at their own valid, so paired sources fire together.
  always_comb begin
    self_ready = 1'b0;
    prev_ready = 1'b0;
    fire       = 1'b0;
    if (state_q == RUN) begin
      case (act_mode.from)
        FROM_SELF: begin
          self_ready = s1_ready;
          fire       = self_valid && s1_ready;
        end
        FROM_PREV: begin
          prev_ready = s1_ready;
          fire       = prev_valid && s1_ready;
        end
        FROM_BOTH: begin
          self_ready = prev_valid && s1_ready;
          prev_ready = self_valid && s1_ready;
          fire       = self_valid && prev_valid && s1_ready;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    noc_vec_lane #(.DW(DW), .SHW(SHW)) u_lane (
      .op        (act_mode.op),
      .from      (act_mode.from),
      .shift_l   (act_shl),
      .shift_r   (act_shr),
      .self_lane (self_data[i*DW +: DW]),
      .prev_lane (prev_data[i*DW +: DW]),
      .relu_en   (s1_relu),
      .s1_lane   (s1_dat[i*DW +: DW]),
      .res_lane  (sum_bus[i*DW +: DW]),
      .sat       (sat_bus[i]),
      .out_lane  (relu_bus[i*DW +: DW])
    );
  end

  // Stage 1: capture the joined beat's lane results whenever the slot is free or moving on.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v    <= 1'b0;
      s1_dat  <= '0;
      s1_sat  <= 1'b0;
      s1_relu <= 1'b0;
    end else if (s1_ready) begin
      s1_v <= fire;
      if (fire) begin
        s1_dat  <= sum_bus;
        s1_sat  <= |sat_bus;
        s1_relu <= op_relu(act_mode.op);
      end
    end
  end

  // Stage 2: output register, held steady while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (!out_valid || out_ready) begin
      out_valid <= s1_v;
      if (s1_v) out_data <= relu_bus;
    end
  end

  // Count saturated beats as they leave stage 1; a newly applied config restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      sat_cnt <= '0;
    else if (apply)
      sat_cnt <= '0;
    else if (s2_adv && s1_sat && !(&sat_cnt))
      sat_cnt <= sat_cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_noc_vec_stream.sv
// Scoreboard bench for noc_vec_stream: integer lane model, handshake-driven push/pop.
// Latency: checks 2-cycle accept-to-valid and back-to-back throughput.
// Backpressure: stalls out_ready, checks held output and ready drop, drains across reconfig.
module tb_noc_vec_stream;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int SHW   = 3;
  localparam int CNTW  = 16;
  localparam int VW    = LANES * DW;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             cfg_valid;
  logic [1:0]       cfg_op, cfg_from;
  logic [SHW-1:0]   cfg_shift_l, cfg_shift_r;
  logic             cfg_busy, cfg_err;
  logic             self_valid, self_ready, prev_valid, prev_ready;
  logic [VW-1:0]    self_data, prev_data, out_data;
  logic             out_valid, out_ready;
  logic [CNTW-1:0]  sat_cnt;

  noc_vec_stream #(.LANES(LANES), .DW(DW), .SHW(SHW), .CNTW(CNTW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_op(cfg_op), .cfg_from(cfg_from),
    .cfg_shift_l(cfg_shift_l), .cfg_shift_r(cfg_shift_r),
    .cfg_busy(cfg_busy), .cfg_err(cfg_err),
    .self_valid(self_valid), .self_ready(self_ready), .self_data(self_data),
    .prev_valid(prev_valid), .prev_ready(prev_ready), .prev_data(prev_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_out_cyc = 0;
  int n_extra = 0;
  int m_op = 0, m_from = 0, m_shl = 0, m_shr = 0, m_sat = 0, m_err = 0;
  bit seen_self_rdy = 1'b0;
  logic [VW-1:0] sb[$];
  int out_cyc[$];

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input int op, input int from);
    if (from == 0) return 1'b1;
    if (op == 1 || op == 3) return from == 3;
    return (from == 1) || (from == 2);
  endfunction

  function automatic logic [VW-1:0] mk(input int l0, input int l1, input int l2, input int l3);
    logic [VW-1:0] r;
    r[0*DW +: DW] = l0[DW-1:0];
    r[1*DW +: DW] = l1[DW-1:0];
    r[2*DW +: DW] = l2[DW-1:0];
    r[3*DW +: DW] = l3[DW-1:0];
    return r;
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
    return r;
  endfunction

  // Integer reference for one beat under the bench's view of the active config.
  task automatic model(input logic [VW-1:0] sv, input logic [VW-1:0] pv,
                       output logic [VW-1:0] res, output bit sat);
    logic signed [DW-1:0] sbyte, pbyte;
    int s, p, v;
    sat = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      sbyte = sv[i*DW +: DW];
      pbyte = pv[i*DW +: DW];
      s = sbyte;
      p = pbyte;
      if (m_op == 1 || m_op == 3) begin
        v = s + ((p <<< m_shl) >>> m_shr);
        if (v > 127) begin v = 127; sat = 1'b1; end
        else if (v < -128) begin v = -128; sat = 1'b1; end
      end else begin
        v = (m_from == 2) ? p : s;
      end
      if ((m_op == 2 || m_op == 3) && v < 0) v = 0;
      res[i*DW +: DW] = v[DW-1:0];
    end
  endtask

  function automatic bit hs_now();
    case (m_from)
      1: return self_ready;
      2: return prev_ready;
      3: return self_ready && prev_ready;
      default: return 1'b0;
    endcase
  endfunction

  // Present one beat on both inputs; push the expectation on the handshake cycle.
  task automatic send_beat(input logic [VW-1:0] sv, input logic [VW-1:0] pv);
    bit ok;
    bit sat;
    logic [VW-1:0] exp;
    ok = 1'b0;
    self_data = sv; prev_data = pv;
    self_valid = 1'b1; prev_valid = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (self_ready) seen_self_rdy = 1'b1;
      if (hs_now()) begin
        ok = 1'b1;
        acc_cyc = cyc;
        model(sv, pv, exp, sat);
        sb.push_back(exp);
        if (sat && m_sat < 65535) m_sat++;
      end
      @(posedge clk); #1;
    end
    self_valid = 1'b0; prev_valid = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic drain_sb();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    chk("drained", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic cfg_pulse(input int op, input int from, input int shl, input int shr);
    cfg_valid = 1'b1;
    cfg_op = op[1:0]; cfg_from = from[1:0];
    cfg_shift_l = shl[SHW-1:0]; cfg_shift_r = shr[SHW-1:0];
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // Wait out the drain, then update the bench's view of the config.
  task automatic cfg_settle(input int op, input int from, input int shl, input int shr);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (!cfg_busy) break;
    end
    chk("busy_clear", cfg_busy, 0);
    chk("empty_at_apply", sb.size(), 0);
    if (legal(op, from)) begin
      m_op = op; m_from = from; m_shl = shl; m_shr = shr; m_sat = 0;
    end else begin
      m_err = 1;
    end
    chk("cfg_err", cfg_err, m_err);
    chk("sat_after_cfg", sat_cnt, m_sat);
    @(posedge clk); #1;
  endtask

  task automatic cfg_set(input int op, input int from, input int shl, input int shr);
    cfg_pulse(op, from, shl, shr);
    cfg_settle(op, from, shl, shr);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output monitor: pops expectations on handshakes and checks held data while stalled.
  initial begin
    bit held_v;
    logic [VW-1:0] held_dat;
    held_v = 1'b0;
    held_dat = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          chk("hold_vld", out_valid, 1);
          chk("hold_dat", out_data, held_dat);
        end
        if (out_valid && out_ready) begin
          out_cyc.push_back(cyc);
          last_out_cyc = cyc;
          if (sb.size() == 0) n_extra++;
          else chk("out_data", out_data, sb.pop_front());
        end
        held_v = out_valid && !out_ready;
        held_dat = out_data;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    cfg_valid = 1'b0; cfg_op = '0; cfg_from = '0; cfg_shift_l = '0; cfg_shift_r = '0;
    self_valid = 1'b0; prev_valid = 1'b0; self_data = '0; prev_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", cfg_busy, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_sat", sat_cnt, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Idle accepts nothing even with both valids up.
    self_valid = 1'b1; prev_valid = 1'b1;
    @(negedge clk);
    chk("idle_rdy", {self_ready, prev_ready}, 0);
    @(posedge clk); #1;
    self_valid = 1'b0; prev_valid = 1'b0;

    // Add-ReLU: saturating lane, negative-to-zero lane, latency.
    cfg_set(3, 3, 0, 0);
    send_beat(mk(100, -20, 0, 0), mk(50, 5, 0, 0));
    drain_sb();
    chk("latency", last_out_cyc - acc_cyc, 2);
    chk("sat_cnt_1", sat_cnt, m_sat);

    // Add with shifts, then a back-to-back burst.
    cfg_set(1, 3, 2, 1);
    send_beat(mk(3, 0, 0, 0), mk(-4, 0, 0, 0));
    drain_sb();
    out_cyc.delete();
    for (int b = 0; b < 8; b++) send_beat(rnd_vec(), rnd_vec());
    drain_sb();
    chk("burst_n", out_cyc.size(), 8);
    chk("burst_span", out_cyc[7] - out_cyc[0], 7);
    chk("burst_sat", sat_cnt, m_sat);

    // Output stall with inputs pending: readies drop, data held, nothing lost.
    fork
      begin
        for (int b = 0; b < 5; b++) send_beat(mk(127, b, 0, 0), mk(100 + b, b, 0, 0));
      end
      begin
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("stall_rdy", {self_ready, prev_ready}, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain_sb();
    chk("stall_sat", sat_cnt, m_sat);

    // Reconfigure mid-stream: busy, inputs blocked, drain, then self passthrough.
    for (int b = 0; b < 3; b++) send_beat(mk(127, 1, 2, 3), mk(90, b, 0, 0));
    cfg_pulse(0, 1, 0, 0);
    self_valid = 1'b1; prev_valid = 1'b1;
    @(negedge clk);
    chk("drain_busy", cfg_busy, 1);
    chk("drain_blk", {self_ready, prev_ready}, 0);
    @(posedge clk); #1;
    self_valid = 1'b0; prev_valid = 1'b0;
    cfg_settle(0, 1, 0, 0);
    for (int b = 0; b < 4; b++) send_beat(rnd_vec(), rnd_vec());
    drain_sb();

    // ReLU on prev only; self must never be offered a ready.
    cfg_set(2, 2, 0, 0);
    seen_self_rdy = 1'b0;
    send_beat(rnd_vec(), mk(-1, 7, -128, 127));
    send_beat(rnd_vec(), rnd_vec());

    // Illegal config is rejected after the drain; prev mode keeps running.
    cfg_set(1, 1, 0, 0);
    send_beat(rnd_vec(), mk(-1, 7, 5, -9));
    drain_sb();
    chk("self_rdy_prev_mode", seen_self_rdy, 0);

    // Reset mid-stream drops in-flight beats and returns to idle.
    out_ready = 1'b0;
    send_beat(rnd_vec(), rnd_vec());
    send_beat(rnd_vec(), rnd_vec());
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_err", cfg_err, 0);
    chk("midrst_sat", sat_cnt, 0);
    sb.delete();
    m_op = 0; m_from = 0; m_shl = 0; m_shr = 0; m_sat = 0; m_err = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    self_valid = 1'b1; prev_valid = 1'b1;
    @(negedge clk);
    chk("midrst_idle_rdy", {self_ready, prev_ready}, 0);
    chk("midrst_busy", cfg_busy, 0);
    @(posedge clk); #1;
    self_valid = 1'b0; prev_valid = 1'b0;
    cfg_set(0, 1, 0, 0);
    send_beat(mk(-5, 9, 0, 1), rnd_vec());
    drain_sb();

    chk("sb_final", sb.size(), 0);
    chk("extra_outputs", n_extra, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
